// File: rtl/rom_burst_sync_if.sv
// Burst request / response bus for rom_burst_sync.
// Optional rsp_parity exists only when ROM_PARITY_EN is defined.
interface rom_burst_sync_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          rsp_err;
`ifdef ROM_PARITY_EN
  logic          rsp_parity;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last,
    input  rsp_err, rsp_parity
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last,
    output rsp_err, rsp_parity
  );
`else
  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last,
    output rsp_err
  );
`endif
endinterface

// File: rtl/rom_burst_sync.sv
// Synchronous-read program ROM streaming bursts over valid/ready.
// Optional feature macro ROM_PARITY_EN adds rsp_parity on the bus.
module rom_burst_sync #(
  parameter int    DW        = 8,
  parameter int    AW        = 3,
  parameter int    DEPTH     = 8,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  rom_burst_sync_if.slave  bus,
  output logic             busy
);
  localparam int NS = LAT + 1;
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] remain;
  logic [AW-1:0] next_addr;
  logic [DW-1:0] rd_word;
  logic          in_range;
  logic          en;
  logic          issue;

  logic [NS-1:0] v_q;
  logic [NS-1:0] l_q;
  logic [NS-1:0] e_q;
  logic [DW-1:0] d_q [NS];
`ifdef ROM_PARITY_EN
  logic [NS-1:0] p_q;
`endif

  function automatic logic [DW-1:0] def_word(
    input logic [AW-1:0] a
  );
    logic [7:0] b;
    b = 8'h00;
    case (32'(a))
      0:       b = 8'h08;
      1:       b = 8'h19;
      2:       b = 8'h4A;
      3:       b = 8'h63;
      4:       b = 8'h84;
      5:       b = 8'hA8;
      default: b = 8'h00;
    endcase
    return DW'(b);
  endfunction

  assign rd_word   = def_word(cur_addr);

  assign in_range  = {1'b0, cur_addr} < DEPTH_V;
  assign next_addr = (cur_addr == LAST_A) ? '0
                   : cur_addr + 1'b1;
  assign en        = !v_q[NS-1] || bus.rsp_ready;
  assign issue     = (state == BURST) && en;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = v_q[NS-1];
  assign bus.rsp_last  = l_q[NS-1];
  assign bus.rsp_err   = e_q[NS-1];
  assign bus.rsp_data  = d_q[NS-1];
`ifdef ROM_PARITY_EN
  assign bus.rsp_parity = p_q[NS-1];
`endif
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
      v_q      <= '0;
      l_q      <= '0;
      e_q      <= '0;
`ifdef ROM_PARITY_EN
      p_q      <= '0;
`endif
      for (int i = 0; i < NS; i++) d_q[i] <= '0;
    end else begin
      if (en) begin
        for (int i = 1; i < NS; i++) begin
          v_q[i] <= v_q[i-1];
          l_q[i] <= l_q[i-1];
          e_q[i] <= e_q[i-1];
          d_q[i] <= d_q[i-1];
`ifdef ROM_PARITY_EN
          p_q[i] <= p_q[i-1];
`endif
        end
        v_q[0] <= issue;
        l_q[0] <= issue && (remain == '0);
        e_q[0] <= issue && !in_range;
        d_q[0] <= (issue && in_range) ? rd_word : '0;
`ifdef ROM_PARITY_EN
        p_q[0] <= (issue && in_range) ? ^rd_word : 1'b0;
`endif
      end
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr <= bus.req_addr;
            remain   <= bus.req_len;
            state    <= BURST;
          end
        end
        BURST: begin
          if (en) begin
            cur_addr <= next_addr;
            remain   <= remain - 1'b1;
            if (remain == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.rsp_valid && bus.rsp_ready
              && bus.rsp_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
